lut_arbiter: RTL and testbench
==============================

Name: lut_arbiter

Overview:
- Round-robin arbiter that shares one synchronous-read lut ROM (offset/sine table, 64x8 by default) between NUM_REQ requesters, e.g. the R/G/B colour channel engines.
- Accepts one address per cycle via a valid/ready handshake and drives the ROM address.
- Tracks the in-flight requester through a 2-stage pipeline and returns the ROM word with a one-hot response strobe.
- Sits between the colour generators and the single lut instance.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 6, ROM address width; equals $clog2 of the lut depth (64).
- DATA_WIDTH, 8, ROM data width; equals the lut width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant (combinational); a transfer occurs when req_valid[i] and req_ready[i] are both high.
- lut_addr  out  ADDR_WIDTH  registered address to lut .addr.
- lut_data  in  DATA_WIDTH  from lut .data; valid one cycle after lut_addr is presented.
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered.
- rsp_data  out  DATA_WIDTH  response word, qualified by rsp_valid.
- busy  out  1  high while any pipeline stage holds a valid request.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - lut_addr=0, rsp_valid=0, rsp_data=0, busy=0, RR pointer=0.
  - Both pipeline valid bits cleared; in-flight requests are discarded with no response.
  - req_ready=0 while reset is high.
- Arbitration (combinational, cycle T):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit gets req_ready; at most one req_ready bit is high.
  - No valid requests -> req_ready=0.
- Pointer update:
  - On a transfer from requester g, ptr <= (g+1) mod NUM_REQ.
  - With no transfer, ptr holds.
  - g = NUM_REQ-1 wraps ptr to 0.
- Requester rule: req_valid and req_addr stay stable until the transfer. The arbiter does not check this; the bench flags violations.
- Pipeline (no stalls; one transfer per cycle sustained):
  - S1, end of T: lut_addr <= req_addr[g], v1 <= 1, id1 <= g. With no transfer, v1 <= 0 and lut_addr holds its last value.
  - ROM, end of T+1: lut samples lut_addr; lut_data is valid during T+2. In parallel, v2 <= v1, id2 <= id1.
  - S2, end of T+2: rsp_valid <= v2 ? onehot(id2) : 0; rsp_data <= lut_data when v2, otherwise holds.
  - Net result: a transfer in cycle T gives rsp_valid high during cycle T+3 for exactly one cycle. Fixed latency of 3.
- Responses have no back-pressure; the requester must consume rsp_data in the strobe cycle.
- Back-to-back transfers in T and T+1 produce responses in T+3 and T+4, in grant order.
- busy = v1 | v2 | (any bit of rsp_valid).
- Simultaneous events:
  - A new grant in the same cycle a response is emitted is allowed.
  - A requester may re-request in the cycle after its own grant. It gets lower priority than the others because ptr has moved.
- Addresses are unsigned 0..2^ADDR_WIDTH-1; there is no range checking.
- id registers are $clog2(NUM_REQ) bits wide, minimum 1.

Test Plan:
- Reset then single request: req_valid=3'b010, req_addr[1]=6'h05 held until ready. Expect req_ready=3'b010 in the same cycle, lut_addr=5 on the next cycle, rsp_valid=3'b010 exactly 3 cycles after the transfer, rsp_data=offset.data[5].
- All three requesters continuously valid, addrs 0x00/0x10/0x3F. Expect grants in the order 0,1,2,0,1,2 (one per cycle); responses also in order 0,1,2,0,1,2; rsp_data matches offset.data[0], [16], [63] for requesters 0/1/2.
- Fairness after skip: only req2 valid, granted; then req0 and req2 valid. Expect req0 granted first (ptr wrapped to 0), then req2.
- Full ROM sweep: requester 0 streams addresses 0..63 back-to-back. Expect 64 consecutive rsp_valid=3'b001 cycles; every rsp_data equals offset.data[i]; errors=0.
- Reset mid-operation: assert reset 1 cycle after two transfers. Expect rsp_valid=0 and busy=0 immediately, no stale response after release, and a first post-reset grant to req0 (ptr=0).
- Idle gap: a transfer, 5 idle cycles, another transfer. Expect lut_addr to hold the previous value while idle, busy to fall 3 cycles after the last transfer, and no spurious rsp_valid.

Source files
------------

// File: rtl/lut_arbiter.sv
// Round-robin arbiter sharing one synchronous-read lut ROM between requesters.
// Fixed 3-cycle latency from grant to one-hot response strobe.
module lut_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         lut_addr,
    input  logic [DATA_WIDTH-1:0]         lut_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]        r_ptr;
    logic [ADDR_WIDTH-1:0] r_lut_addr;
    logic                  r_v1;
    logic                  r_v2;
    logic [IDW-1:0]        r_id1;
    logic [IDW-1:0]        r_id2;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic [NUM_REQ-1:0]    w_ready;
    logic [IDW-1:0]        w_gnt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_xfer;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_ready = '0;
        w_gnt   = '0;
        w_addr  = '0;
        w_xfer  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_xfer && !reset && req_valid[idx]) begin
                w_xfer       = 1'b1;
                w_ready[idx] = 1'b1;
                w_gnt        = IDW'(idx);
                w_addr       = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_lut_addr  <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_id1       <= '0;
            r_id2       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr      <= (w_gnt == LAST) ? '0 : w_gnt + 1'b1;
                r_lut_addr <= w_addr;
            end
            r_v1  <= w_xfer;
            r_id1 <= w_gnt;
            // ROM samples lut_addr while the tag moves to stage 2.
            r_v2  <= r_v1;
            r_id2 <= r_id1;
            r_rsp_valid <= r_v2 ? (NUM_REQ'(1) << r_id2) : '0;
            if (r_v2) begin
                r_rsp_data <= lut_data;
            end
        end
    end

    assign req_ready = w_ready;
    assign lut_addr  = r_lut_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_v1 | r_v2 | (|r_rsp_valid);

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter with a synchronous-read ROM model.
// Also watches that requesters hold valid/addr stable until granted.
module tb_lut_arbiter;

    localparam int N  = 3;
    localparam int AW = 6;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   lut_addr;
    logic [DW-1:0]   lut_data = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    lut_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .lut_addr(lut_addr),
        .lut_data(lut_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [5:0] a);
        logic [7:0] t;
        t = {2'b00, a} * 8'd37;
        return t ^ 8'hA5;
    endfunction

    always @(posedge clk) lut_data <= rom(lut_addr);

    // Requester-rule monitor: a pending request must stay put until granted.
    logic [N-1:0]    pend = '0;
    logic [N*AW-1:0] paddr = '0;
    always @(posedge clk) begin
        if (reset) begin
            pend = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    n_checks++;
                    if (!req_valid[i] || req_addr[i*AW +: AW] !== paddr[i*AW +: AW]) begin
                        n_fail++;
                        $display("FAIL rule req%0d: valid=%b addr=%h required held addr=%h",
                                 i, req_valid[i], req_addr[i*AW +: AW], paddr[i*AW +: AW]);
                    end
                end
            end
            pend  = req_valid & ~req_ready;
            paddr = req_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tick();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 000", req_ready);
        end
        n_checks++;
        if (lut_addr !== 6'h00 || rsp_valid !== 3'b000 || rsp_data !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: addr=%h rv=%b rd=%h busy=%b required 0/000/0/0",
                     lut_addr, rsp_valid, rsp_data, busy);
        end
        tick();
        req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        tick();
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 6'h05;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL single_ready: got %b required 010", req_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            req_valid = '0;
            #1;
            if (c == 1) begin
                n_checks++;
                if (lut_addr !== 6'h05 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_addr: addr=%h busy=%b required 05/1", lut_addr, busy);
                end
            end
            n_checks++;
            if (rsp_valid !== ((c == 3) ? 3'b010 : 3'b000)) begin
                n_fail++;
                $display("FAIL single_rsp c%0d: got %b", c, rsp_valid);
            end
            if (c == 3) begin
                n_checks++;
                if (rsp_data !== rom(6'h05)) begin
                    n_fail++;
                    $display("FAIL single_data: got %h required %h", rsp_data, rom(6'h05));
                end
            end
            if (c == 4) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_busy: got %b required 0", busy);
                end
            end
        end
    endtask

    task automatic test_all();
        logic [5:0] a [3];
        logic [2:0] ev;
        a[0] = 6'h00;
        a[1] = 6'h10;
        a[2] = 6'h3F;
        reset_dut();
        for (int c = 0; c <= 9; c++) begin
            tick();
            ev = (c <= 3) ? 3'b111 : (c == 4) ? 3'b110 : (c == 5) ? 3'b100 : 3'b000;
            req_valid = ev;
            req_addr = {a[2], a[1], a[0]};
            #1;
            if (c < 6) begin
                n_checks++;
                if (req_ready !== (3'b001 << (c % 3))) begin
                    n_fail++;
                    $display("FAIL all_grant c%0d: got %b required %b", c, req_ready, 3'b001 << (c % 3));
                end
            end
            if (c >= 3 && c <= 8) begin
                n_checks++;
                if (rsp_valid !== (3'b001 << ((c - 3) % 3)) || rsp_data !== rom(a[(c - 3) % 3])) begin
                    n_fail++;
                    $display("FAIL all_rsp c%0d: got %b/%h required %b/%h", c, rsp_valid, rsp_data,
                             3'b001 << ((c - 3) % 3), rom(a[(c - 3) % 3]));
                end
            end else if (c == 9) begin
                n_checks++;
                if (rsp_valid !== 3'b000) begin
                    n_fail++;
                    $display("FAIL all_tail: got %b required 000", rsp_valid);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [2:0] vin [4];
        logic [2:0] exp [4];
        vin[0] = 3'b100; exp[0] = 3'b100;
        vin[1] = 3'b101; exp[1] = 3'b001;
        vin[2] = 3'b100; exp[2] = 3'b100;
        vin[3] = 3'b000; exp[3] = 3'b000;
        reset_dut();
        req_addr = {6'h03, 6'h02, 6'h01};
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid = vin[c];
            #1;
            n_checks++;
            if (req_ready !== exp[c]) begin
                n_fail++;
                $display("FAIL fair c%0d: got %b required %b", c, req_ready, exp[c]);
            end
        end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_sweep();
        reset_dut();
        for (int c = 0; c <= 67; c++) begin
            tick();
            req_valid = (c < 64) ? 3'b001 : 3'b000;
            req_addr[0 +: AW] = AW'(c);
            #1;
            if (c < 64) begin
                n_checks++;
                if (req_ready !== 3'b001) begin
                    n_fail++;
                    $display("FAIL sweep_grant c%0d: got %b required 001", c, req_ready);
                end
            end
            if (c >= 3) begin
                n_checks++;
                if (c <= 66 && (rsp_valid !== 3'b001 || rsp_data !== rom(AW'(c - 3)))) begin
                    n_fail++;
                    $display("FAIL sweep_rsp a%0d: got %b/%h required 001/%h",
                             c - 3, rsp_valid, rsp_data, rom(AW'(c - 3)));
                end else if (c == 67 && rsp_valid !== 3'b000) begin
                    n_fail++;
                    $display("FAIL sweep_tail: got %b required 000", rsp_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] vin [3];
        logic [2:0] exp [3];
        reset_dut();
        req_addr = {6'h07, 6'h02, 6'h01};
        tick();
        req_valid = 3'b011;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL mid_g0: got %b required 001", req_ready);
        end
        tick();
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0 || lut_addr !== 6'h00) begin
            n_fail++;
            $display("FAIL mid_reset: rv=%b busy=%b addr=%h required 000/0/00", rsp_valid, busy, lut_addr);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            n_checks++;
            if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale c%0d: rv=%b busy=%b required 000/0", c, rsp_valid, busy);
            end
        end
        vin[0] = 3'b111; exp[0] = 3'b001;
        vin[1] = 3'b110; exp[1] = 3'b010;
        vin[2] = 3'b100; exp[2] = 3'b100;
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid = vin[c];
            #1;
            n_checks++;
            if (req_ready !== exp[c]) begin
                n_fail++;
                $display("FAIL mid_post c%0d: got %b required %b", c, req_ready, exp[c]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid = '0;
        end
    endtask

    task automatic test_idle_gap();
        tick();
        req_valid = 3'b001;
        req_addr[0 +: AW] = 6'h11;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL gap_g0: got %b required 001", req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            req_valid = (c == 6) ? 3'b001 : 3'b000;
            req_addr[0 +: AW] = (c == 6) ? 6'h22 : 6'h11;
            #1;
            n_checks++;
            if (lut_addr !== 6'h11) begin
                n_fail++;
                $display("FAIL gap_hold c%0d: got %h required 11", c, lut_addr);
            end
            n_checks++;
            if (rsp_valid !== ((c == 3) ? 3'b001 : 3'b000) || busy !== (c <= 3)) begin
                n_fail++;
                $display("FAIL gap_state c%0d: rv=%b busy=%b", c, rsp_valid, busy);
            end
            if (c == 3) begin
                n_checks++;
                if (rsp_data !== rom(6'h11)) begin
                    n_fail++;
                    $display("FAIL gap_data: got %h required %h", rsp_data, rom(6'h11));
                end
            end
            if (c == 6) begin
                n_checks++;
                if (req_ready !== 3'b001) begin
                    n_fail++;
                    $display("FAIL gap_g1: got %b required 001", req_ready);
                end
            end
        end
        for (int c = 7; c <= 10; c++) begin
            tick();
            req_valid = '0;
            #1;
            if (c == 7) begin
                n_checks++;
                if (lut_addr !== 6'h22) begin
                    n_fail++;
                    $display("FAIL gap_addr2: got %h required 22", lut_addr);
                end
            end
            n_checks++;
            if (rsp_valid !== ((c == 9) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL gap_rsp2 c%0d: got %b", c, rsp_valid);
            end
            if (c == 9) begin
                n_checks++;
                if (rsp_data !== rom(6'h22)) begin
                    n_fail++;
                    $display("FAIL gap_data2: got %h required %h", rsp_data, rom(6'h22));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_fairness();
        test_sweep();
        test_reset_mid();
        test_idle_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
